// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// The state encoding is 2 bits and the zero register is r0.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_BUBBLE   = 2'b01,
    ST_FLUSH    = 2'b10,
    ST_MEM_WAIT = 2'b11
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load in EX feeds a source register of the instruction in ID. Writes to r0 never count.
  function automatic logic load_use(input logic       ex_memread,
                                    input logic [4:0] ex_rt,
                                    input logic [4:0] id_rs,
                                    input logic [4:0] id_rt,
                                    input logic       id_uses_rt);
    return ex_memread && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and register-bank controls exchanged between the pipeline and its controller.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       mem_busy;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_aload;
  logic       idex_aload;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken, mem_busy,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_aload, idex_aload
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken, mem_busy,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_aload, idex_aload
  );
endinterface

// File: rtl/pipe_ctrl_satcnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module pipe_ctrl_satcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Enable/aload sequencing for the PC and pipeline register banks: load-use bubbles,
// taken-branch flushes, data-memory wait freeze, plus perf counters and a timeout flag.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic                clk,
  input  logic                arst,
  pipe_hazard_ctrl_if.slave   hz,
  output logic [CNT_W-1:0]    bubble_cnt,
  output logic [CNT_W-1:0]    flush_cnt,
  output logic [CNT_W-1:0]    wait_cnt,
  output logic                mem_timeout
);

  state_t           state, state_nxt;
  logic             lu;
  logic             en_front, en_back;
  logic             inc_bubble, inc_flush, inc_wait;
  logic             ifid_aload_q, idex_aload_q;
  logic [CNT_W-1:0] wait_run, wait_run_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Priority is the same in every state; the state only shapes the registered aloads.
  always_comb begin
    state_nxt  = ST_RUN;
    en_front   = 1'b1;
    en_back    = 1'b1;
    inc_bubble = 1'b0;
    inc_flush  = 1'b0;
    inc_wait   = 1'b0;
    lu = load_use(hz.ex_memread, hz.ex_rt, hz.id_rs, hz.id_rt, hz.id_uses_rt);
    if (hz.mem_busy) begin
      en_front  = 1'b0;
      en_back   = 1'b0;
      state_nxt = ST_MEM_WAIT;
      inc_wait  = 1'b1;
    end else if (hz.ex_branch_taken) begin
      state_nxt = ST_FLUSH;
      inc_flush = 1'b1;
    end else if (lu) begin
      en_front   = 1'b0;
      state_nxt  = ST_BUBBLE;
      inc_bubble = 1'b1;
    end
  end

  // Being in MEM_WAIT means the previous cycle was busy, so the run continues.
  always_comb begin
    wait_run_nxt = '0;
    if (hz.mem_busy) begin
      wait_run_nxt = (state == ST_MEM_WAIT) ? sat_inc(wait_run) : CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state        <= ST_RUN;
      ifid_aload_q <= 1'b0;
      idex_aload_q <= 1'b0;
      wait_run     <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      ifid_aload_q <= (state_nxt == ST_FLUSH);
      idex_aload_q <= (state_nxt == ST_FLUSH) || (state_nxt == ST_BUBBLE);
      wait_run     <= wait_run_nxt;
      if (hz.mem_busy && (wait_run_nxt >= CNT_W'(WAIT_MAX))) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Aloads come straight from flops so the async-load pins never see a decode glitch.
  assign hz.ifid_aload = ifid_aload_q;
  assign hz.idex_aload = idex_aload_q;
  assign hz.pc_en      = arst & en_front;
  assign hz.ifid_en    = arst & en_front;
  assign hz.idex_en    = arst & en_back;
  assign hz.exmem_en   = arst & en_back;
  assign hz.memwb_en   = arst & en_back;

  pipe_ctrl_satcnt #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk), .arst (arst), .inc (inc_bubble), .q (bubble_cnt)
  );

  pipe_ctrl_satcnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk), .arst (arst), .inc (inc_flush), .q (flush_cnt)
  );

  pipe_ctrl_satcnt #(.W(CNT_W)) u_wait_cnt (
    .clk (clk), .arst (arst), .inc (inc_wait), .q (wait_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table for the enable decode plus
// hand-written sequences for bubble, flush, memory wait, timeout, reset and saturation.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if ifa ();
  pipe_hazard_ctrl_if ifb ();

  logic [15:0] bubble_a, flush_a, wait_a;
  logic        timeout_a;
  logic [1:0]  bubble_b, flush_b, wait_b;
  logic        timeout_b;

  pipe_hazard_ctrl #(.CNT_W(16), .WAIT_MAX(4)) dut (
    .clk (clk), .arst (arst), .hz (ifa),
    .bubble_cnt (bubble_a), .flush_cnt (flush_a), .wait_cnt (wait_a),
    .mem_timeout (timeout_a)
  );

  pipe_hazard_ctrl #(.CNT_W(2), .WAIT_MAX(3)) dut_sat (
    .clk (clk), .arst (arst), .hz (ifb),
    .bubble_cnt (bubble_b), .flush_cnt (flush_b), .wait_cnt (wait_b),
    .mem_timeout (timeout_b)
  );

  assign ifb.id_rs           = ifa.id_rs;
  assign ifb.id_rt           = ifa.id_rt;
  assign ifb.id_uses_rt      = ifa.id_uses_rt;
  assign ifb.ex_memread      = ifa.ex_memread;
  assign ifb.ex_rt           = ifa.ex_rt;
  assign ifb.ex_branch_taken = ifa.ex_branch_taken;
  assign ifb.mem_busy        = ifa.mem_busy;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] en_vec();
    return {ifa.pc_en, ifa.ifid_en, ifa.idex_en, ifa.exmem_en, ifa.memwb_en};
  endfunction

  function automatic logic [1:0] aload_vec();
    return {ifa.ifid_aload, ifa.idex_aload};
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic memread, input logic [4:0] ert,
                       input logic br, input logic busy);
    ifa.id_rs           = rs;
    ifa.id_rt           = rt;
    ifa.id_uses_rt      = uses_rt;
    ifa.ex_memread      = memread;
    ifa.ex_rt           = ert;
    ifa.ex_branch_taken = br;
    ifa.mem_busy        = busy;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    arst = 1'b0;
    idle();
    step();
    arst = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       uses_rt, memread;
    logic [4:0] ert;
    logic       br, busy;
    logic [4:0] exp_en;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"no_hazard",     5'd1, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 5'b11111};
    vecs[1] = '{"lu_rs",         5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 5'b00111};
    vecs[2] = '{"lu_r0",         5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'b11111};
    vecs[3] = '{"lu_rt",         5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'b00111};
    vecs[4] = '{"rt_not_used",   5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 5'b11111};
    vecs[5] = '{"not_load",      5'd8, 5'd2, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 5'b11111};
    vecs[6] = '{"branch_and_lu", 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 5'b11111};
    vecs[7] = '{"busy_branch",   5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'b00000};
    vecs[8] = '{"busy_lu",       5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 5'b00000};

    idle();
    #2;
    // Reset state
    chk("rst_en", 32'(en_vec()), 32'h0);
    chk("rst_aload", 32'(aload_vec()), 32'h0);
    chk("rst_cnt", {bubble_a[7:0], flush_a[7:0], wait_a[7:0], 7'd0, timeout_a}, 32'h0);
    step();
    arst = 1'b1;

    // Load-use bubble
    drive(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    #2;
    chk("lu_en", 32'(en_vec()), 32'h07);
    step();
    idle();
    #2;
    chk("lu_aload", 32'(aload_vec()), 32'h1);
    chk("lu_bubble_cnt", 32'(bubble_a), 32'd1);
    step();
    chk("lu_aload_drop", 32'(aload_vec()), 32'h0);
    drive(5'd0, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    #2;
    chk("r0_en", 32'(en_vec()), 32'h1f);
    step();
    idle();
    chk("r0_aload", 32'(aload_vec()), 32'h0);
    chk("r0_bubble_cnt", 32'(bubble_a), 32'd1);

    // Enable decode table
    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].memread,
            vecs[i].ert, vecs[i].br, vecs[i].busy);
      #2;
      chk(vecs[i].name, 32'(en_vec()), 32'(vecs[i].exp_en));
      step();
    end

    // Branch with coincident load-use, then reset in the middle of FLUSH
    do_reset();
    drive(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    #2;
    chk("br_lu_en", 32'(en_vec()), 32'h1f);
    step();
    idle();
    #1;
    chk("flush_aload", 32'(aload_vec()), 32'h3);
    chk("flush_cnt", 32'(flush_a), 32'd1);
    chk("flush_no_bubble", 32'(bubble_a), 32'd0);
    arst = 1'b0;
    #1;
    chk("midflush_rst_aload", 32'(aload_vec()), 32'h0);
    chk("midflush_rst_en", 32'(en_vec()), 32'h0);
    chk("midflush_rst_cnt", 32'(flush_a), 32'd0);
    step();
    arst = 1'b1;

    // Branch held through three busy cycles
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("busy_en_%0d", c), 32'(en_vec()), 32'h0);
      chk($sformatf("busy_aload_%0d", c), 32'(aload_vec()), 32'h0);
      step();
    end
    chk("wait_cnt3", 32'(wait_a), 32'd3);
    chk("no_timeout3", 32'(timeout_a), 32'd0);
    chk("no_flush_yet", 32'(flush_a), 32'd0);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    #2;
    chk("busy_drop_en", 32'(en_vec()), 32'h1f);
    step();
    idle();
    chk("late_flush_aload", 32'(aload_vec()), 32'h3);
    chk("late_flush_cnt", 32'(flush_a), 32'd1);

    // Memory timeout after WAIT_MAX consecutive busy cycles
    do_reset();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1);
    step();
    step();
    step();
    chk("timeout_before", 32'(timeout_a), 32'd0);
    step();
    chk("timeout_set", 32'(timeout_a), 32'd1);
    idle();
    step();
    step();
    chk("timeout_sticky", 32'(timeout_a), 32'd1);
    chk("timeout_wait_cnt", 32'(wait_a), 32'd4);

    // Counter saturation at CNT_W=2
    do_reset();
    drive(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) step();
    idle();
    chk("sat_bubble_w2", 32'(bubble_b), 32'd3);
    chk("sat_bubble_w16", 32'(bubble_a), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
